// File: rtl/adt7310_measure_fsm.sv
// ADT7310 one-shot measurement sequencer: configure, wait for conversion, read temperature.
// Optional transfer watchdog enabled by defining ADT7310_MEASURE_TIMEOUT_EN.
module adt7310_measure_fsm #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned WaitCntWidth  = 16,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic                    Reset_n_i,
  input  logic                    Clk_i,
  input  logic                    Start_i,
  output logic                    Done_o,
  output logic                    Error_o,
  output logic [DataWidth-1:0]    Byte0_o,
  output logic [DataWidth-1:0]    Byte1_o,
  output logic                    SensorCS_n_o,
  output logic                    SPI_Write_o,
  output logic                    SPI_ReadNext_o,
  output logic [DataWidth-1:0]    SPI_Data_o,
  input  logic [DataWidth-1:0]    SPI_Data_i,
  input  logic                    SPI_FIFOFull_i,
  input  logic                    SPI_FIFOEmpty_i,
  input  logic                    SPI_Transmission_i,
  input  logic [WaitCntWidth-1:0] ParamWaitCycles_i
);

  localparam logic [DataWidth-1:0] CmdWrCfg  = DataWidth'(8'h08);
  localparam logic [DataWidth-1:0] CfgOneSht = DataWidth'(8'h20);
  localparam logic [DataWidth-1:0] CmdRdTemp = DataWidth'(8'h50);
  localparam logic [DataWidth-1:0] Dummy     = DataWidth'(8'hFF);

  typedef enum logic [3:0] {
    StIdle, StCfg1, StCfg2, StCfgWait, StCfgFlush, StConv, StRd1, StRd2, StRd3,
    StRdWait, StGet0, StGet1, StGet2, StAbort
  } state_e;

  state_e                  state_q, state_d;
  logic [WaitCntWidth-1:0] wait_q, wait_d;
  logic [DataWidth-1:0]    byte0_q, byte0_d, byte1_q, byte1_d;
  logic                    done_q, done_d;

`ifdef ADT7310_MEASURE_TIMEOUT_EN
  localparam int unsigned WdogWidth = $clog2(TimeoutCycles + 1);
  logic [WdogWidth-1:0] wdog_q, wdog_d;
  logic                 error_q, error_d;
  logic                 in_wait;
  assign in_wait = (state_q == StCfgWait) || (state_q == StRdWait);
  assign Error_o = error_q;
`else
  assign Error_o = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    byte0_d        = byte0_q;
    byte1_d        = byte1_q;
    done_d         = 1'b0;
    SensorCS_n_o   = 1'b1;
    SPI_Write_o    = 1'b0;
    SPI_ReadNext_o = 1'b0;
    SPI_Data_o     = '0;
`ifdef ADT7310_MEASURE_TIMEOUT_EN
    wdog_d  = '0;
    error_d = 1'b0;
`endif
    unique case (state_q)
      // done_q marks the idle cycle in which Done_o is visible; a Start_i there is dropped.
      StIdle: if (Start_i && !done_q) state_d = StCfg1;
      StCfg1: begin
        SensorCS_n_o = 1'b0;
        SPI_Data_o   = CmdWrCfg;
        SPI_Write_o  = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = StCfg2;
      end
      StCfg2: begin
        SensorCS_n_o = 1'b0;
        SPI_Data_o   = CfgOneSht;
        SPI_Write_o  = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = StCfgWait;
      end
      StCfgWait: begin
        SensorCS_n_o = 1'b0;
        if (!SPI_Transmission_i) state_d = StCfgFlush;
      end
      StCfgFlush: begin
        if (!SPI_FIFOEmpty_i) begin
          SPI_ReadNext_o = 1'b1;
        end else begin
          wait_d  = ParamWaitCycles_i;
          state_d = StConv;
        end
      end
      StConv: begin
        if (wait_q == '0) state_d = StRd1;
        else              wait_d  = wait_q - 1'b1;
      end
      StRd1: begin
        SensorCS_n_o = 1'b0;
        SPI_Data_o   = CmdRdTemp;
        SPI_Write_o  = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = StRd2;
      end
      StRd2: begin
        SensorCS_n_o = 1'b0;
        SPI_Data_o   = Dummy;
        SPI_Write_o  = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = StRd3;
      end
      StRd3: begin
        SensorCS_n_o = 1'b0;
        SPI_Data_o   = Dummy;
        SPI_Write_o  = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = StRdWait;
      end
      StRdWait: begin
        SensorCS_n_o = 1'b0;
        if (!SPI_Transmission_i) state_d = StGet0;
      end
      StGet0: if (!SPI_FIFOEmpty_i) begin
        SPI_ReadNext_o = 1'b1;
        state_d        = StGet1;
      end
      StGet1: if (!SPI_FIFOEmpty_i) begin
        SPI_ReadNext_o = 1'b1;
        byte1_d        = SPI_Data_i;
        state_d        = StGet2;
      end
      StGet2: if (!SPI_FIFOEmpty_i) begin
        SPI_ReadNext_o = 1'b1;
        byte0_d        = SPI_Data_i;
        done_d         = 1'b1;
        state_d        = StIdle;
      end
      StAbort: begin
`ifdef ADT7310_MEASURE_TIMEOUT_EN
        if (!SPI_FIFOEmpty_i) begin
          SPI_ReadNext_o = 1'b1;
        end else begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
`ifdef ADT7310_MEASURE_TIMEOUT_EN
    if (in_wait && SPI_Transmission_i) begin
      if (wdog_q == WdogWidth'(TimeoutCycles - 1)) state_d = StAbort;
      else                                         wdog_d  = wdog_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= StIdle;
      wait_q  <= '0;
      byte0_q <= '0;
      byte1_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
      done_q  <= done_d;
    end
  end

`ifdef ADT7310_MEASURE_TIMEOUT_EN
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end
`endif

  assign Done_o  = done_q;
  assign Byte0_o = byte0_q;
  assign Byte1_o = byte1_q;

endmodule

// File: tb/tb_adt7310_measure_fsm.sv
// Directed bench for adt7310_measure_fsm with a behavioural SPI master/ADT7310 model
// and scoreboards for TX bytes and measurement results.
module tb_adt7310_measure_fsm;

  logic        Reset_n_i, Clk_i, Start_i;
  logic        Done_o, Error_o, SensorCS_n_o, SPI_Write_o, SPI_ReadNext_o;
  logic [7:0]  Byte0_o, Byte1_o, SPI_Data_o, SPI_Data_i;
  logic        SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i;
  logic [15:0] ParamWaitCycles_i;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx[$];
  logic [16:0] exp_res[$];
  logic [7:0]  resp_q[$];
  logic [7:0]  rx_q[$];
  int done_cnt = 0;
  int hi_cnt = 0;
  int last_gap = 0;
  int busy = 0;
  bit trans_stuck = 0;
  logic cs_prev = 1'b1;

  adt7310_measure_fsm dut (
    .Reset_n_i          (Reset_n_i),
    .Clk_i              (Clk_i),
    .Start_i            (Start_i),
    .Done_o             (Done_o),
    .Error_o            (Error_o),
    .Byte0_o            (Byte0_o),
    .Byte1_o            (Byte1_o),
    .SensorCS_n_o       (SensorCS_n_o),
    .SPI_Write_o        (SPI_Write_o),
    .SPI_ReadNext_o     (SPI_ReadNext_o),
    .SPI_Data_o         (SPI_Data_o),
    .SPI_Data_i         (SPI_Data_i),
    .SPI_FIFOFull_i     (SPI_FIFOFull_i),
    .SPI_FIFOEmpty_i    (SPI_FIFOEmpty_i),
    .SPI_Transmission_i (SPI_Transmission_i),
    .ParamWaitCycles_i  (ParamWaitCycles_i)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI master + sensor model: decide on the falling edge, update just after the rising edge.
  initial begin
    bit w, r;
    SPI_Data_i = '0; SPI_FIFOEmpty_i = 1'b1; SPI_Transmission_i = 1'b0;
    forever begin
      @(negedge Clk_i);
      w = SPI_Write_o && !SPI_FIFOFull_i && Reset_n_i;
      r = SPI_ReadNext_o && Reset_n_i;
      @(posedge Clk_i);
      #1;
      if (!Reset_n_i) begin
        rx_q.delete();
        busy = 0;
      end else begin
        if (w) begin
          rx_q.push_back(resp_q.size() != 0 ? resp_q.pop_front() : 8'h00);
          busy += 4;
        end else if (busy > 0) busy--;
        if (r && rx_q.size() != 0) void'(rx_q.pop_front());
      end
      SPI_Transmission_i = (busy > 0) || trans_stuck;
      SPI_FIFOEmpty_i    = (rx_q.size() == 0);
      SPI_Data_i         = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
  end

  // Monitor: scoreboard compares and CS-high gap measurement.
  always @(negedge Clk_i) begin
    if (Reset_n_i) begin
      if (SPI_FIFOFull_i)  check("no_write_while_full", 32'(SPI_Write_o), 32'd0);
      if (SPI_FIFOEmpty_i) check("no_pop_while_empty", 32'(SPI_ReadNext_o), 32'd0);
      if (SPI_Write_o && !SPI_FIFOFull_i) begin
        check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) check("tx_byte", 32'(SPI_Data_o), 32'(exp_tx.pop_front()));
      end
      if (Done_o) begin
        done_cnt++;
        check("result_expected", 32'(exp_res.size() != 0), 32'd1);
        if (exp_res.size() != 0)
          check("result", 32'({Byte1_o, Byte0_o, Error_o}), 32'(exp_res.pop_front()));
      end
      if (SensorCS_n_o) hi_cnt++;
      else begin
        if (cs_prev) last_gap = hi_cnt;
        hi_cnt = 0;
      end
      cs_prev = SensorCS_n_o;
    end
  end

  task automatic queue_meas(input logic [7:0] b1, input logic [7:0] b0, input int p);
    ParamWaitCycles_i = 16'(p);
    resp_q.push_back(8'h00); resp_q.push_back(8'h00);
    resp_q.push_back(8'h00); resp_q.push_back(b1); resp_q.push_back(b0);
    exp_tx.push_back(8'h08); exp_tx.push_back(8'h20);
    exp_tx.push_back(8'h50); exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
    exp_res.push_back({b1, b0, 1'b0});
  endtask

  task automatic pulse_start();
    @(negedge Clk_i) Start_i = 1'b1;
    @(negedge Clk_i) Start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int n);
    int s = done_cnt;
    n = 0;
    while (done_cnt == s && n < budget) begin
      @(posedge Clk_i);
      n++;
    end
    check({tag, "_done_count"}, 32'(done_cnt - s), 32'd1);
  endtask

  initial begin
    int n, s;
    Reset_n_i = 1'b0; Start_i = 1'b0; SPI_FIFOFull_i = 1'b0; ParamWaitCycles_i = '0;
    repeat (3) @(negedge Clk_i);
    check("rst_cs", 32'(SensorCS_n_o), 32'd1);
    check("rst_done", 32'(Done_o), 32'd0);
    check("rst_error", 32'(Error_o), 32'd0);
    check("rst_bytes", 32'({Byte1_o, Byte0_o}), 32'd0);
    check("rst_spi_strobes", 32'({SPI_Write_o, SPI_ReadNext_o}), 32'd0);
    Reset_n_i = 1'b1;
    repeat (2) @(negedge Clk_i);

    // Basic measurement
    queue_meas(8'h0C, 8'h80, 3);
    pulse_start();
    wait_done(500, "basic", n);
    @(negedge Clk_i);
    check("done_pulse_width", 32'(Done_o), 32'd0);
    check("basic_bytes", 32'({Byte1_o, Byte0_o}), 32'h0C80);
    check("basic_conv_gap", 32'(last_gap), 32'd7);

    // Long conversion wait: 3 flush cycles + 101 conversion cycles with CS high
    queue_meas(8'h19, 8'h40, 100);
    pulse_start();
    wait_done(800, "long_wait", n);
    check("long_conv_gap", 32'(last_gap), 32'd104);

    // TX FIFO full for 5 cycles in the second read write
    queue_meas(8'h7F, 8'h01, 2);
    pulse_start();
    n = 0;
    while (exp_tx.size() != 2 && n < 300) begin
      @(posedge Clk_i);
      n++;
    end
    check("stall_reached_rd2", 32'(exp_tx.size()), 32'd2);
    #1 SPI_FIFOFull_i = 1'b1;
    repeat (5) @(posedge Clk_i);
    check("stall_no_tx_consumed", 32'(exp_tx.size()), 32'd2);
    #1 SPI_FIFOFull_i = 1'b0;
    wait_done(300, "stall", n);
    check("stall_bytes", 32'({Byte1_o, Byte0_o}), 32'h7F01);

    // Start held high through a measurement, including the Done_o cycle
    queue_meas(8'h55, 8'hAA, 5);
    s = done_cnt;
    @(negedge Clk_i) Start_i = 1'b1;
    for (int k = 0; k < 400 && !Done_o; k++) @(negedge Clk_i);
    check("repeat_start_done", 32'(Done_o), 32'd1);
    @(negedge Clk_i) Start_i = 1'b0;
    repeat (10) @(negedge Clk_i);
    check("repeat_single_done", 32'(done_cnt - s), 32'd1);
    check("repeat_idle_cs", 32'(SensorCS_n_o), 32'd1);
    queue_meas(8'hAB, 8'hCD, 0);
    pulse_start();
    wait_done(300, "after_repeat", n);
    check("zero_wait_gap", 32'(last_gap), 32'd4);
    check("after_repeat_bytes", 32'({Byte1_o, Byte0_o}), 32'hABCD);

    // Reset while waiting for the read burst
    queue_meas(8'h12, 8'h34, 2);
    s = done_cnt;
    pulse_start();
    n = 0;
    while (exp_tx.size() != 0 && n < 300) begin
      @(posedge Clk_i);
      n++;
    end
    #1 trans_stuck = 1'b1;
    repeat (3) @(posedge Clk_i);
    @(negedge Clk_i) Reset_n_i = 1'b0;
    #1;
    check("rst_mid_cs", 32'(SensorCS_n_o), 32'd1);
    check("rst_mid_bytes", 32'({Byte1_o, Byte0_o}), 32'd0);
    check("rst_mid_done", 32'(Done_o), 32'd0);
    exp_res.delete();
    resp_q.delete();
    @(negedge Clk_i) Reset_n_i = 1'b1;
    trans_stuck = 1'b0;
    repeat (3) @(negedge Clk_i);
    check("rst_mid_no_done", 32'(done_cnt - s), 32'd0);
    queue_meas(8'h0F, 8'hF0, 1);
    pulse_start();
    wait_done(300, "post_reset", n);
    check("post_reset_bytes", 32'({Byte1_o, Byte0_o}), 32'h0FF0);

`ifdef ADT7310_MEASURE_TIMEOUT_EN
    // Transmission stuck: watchdog ends the sequence with Error_o, bytes held
    trans_stuck = 1'b1;
    ParamWaitCycles_i = '0;
    exp_tx.push_back(8'h08); exp_tx.push_back(8'h20);
    exp_res.push_back({8'h0F, 8'hF0, 1'b1});
    pulse_start();
    wait_done(2000, "timeout", n);
    check("timeout_latency_window", 32'(n >= 1023 && n <= 1040), 32'd1);
    check("timeout_bytes_held", 32'({Byte1_o, Byte0_o}), 32'h0FF0);
    trans_stuck = 1'b0;
    repeat (5) @(negedge Clk_i);
`endif

    check("scoreboards_drained", 32'(exp_tx.size() + exp_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
